coincidence_gated_counter: RTL

- Parametrised successor to the pairwise coincidence detector.
- Rising-edge detects NCHAN inputs, delays each channel by a programmable number of cycles, and counts pairwise coincidences within a programmable window.
- Counts accumulate over a timed acquisition gate, with saturating singles and pair counters.
- Results are published as a stable snapshot with a done pulse for the readout logic.

---
 rtl/coincidence_gated_counter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/coincidence_gated_counter.sv
// ============================================================================
// coincidence_gated_counter : edge-detect, delay and window NCHAN inputs, then
// count singles and pairwise coincidences over a timed gate.  Rev 1.0
// ============================================================================
`default_nettype none

module coincidence_gated_counter #(
  parameter int NCHAN = 4,
  parameter int NBITS = 4,
  parameter int NREGS = 16,
  parameter int WBITS = 4,
  parameter int GBITS = 16,
  parameter int CBITS = 16,
  localparam int NCOMB = NCHAN * (NCHAN - 1) / 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NCHAN-1:0] channels_i,
  input  logic [NBITS-1:0] delays_i [NCHAN],
  input  logic [WBITS-1:0] window_i,
  input  logic [GBITS-1:0] gate_period_i,
  input  logic             start_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CBITS-1:0] singles_o [NCHAN],
  output logic [CBITS-1:0] counts_o [NCOMB]
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int               IW    = (NREGS > 2) ? $clog2(NREGS) : 1;
  localparam logic [CBITS-1:0] C_MAX = '1;

  state_e           state_q;
  logic [NCHAN-1:0] prev_q;
  logic [NCHAN-1:0] pulse;
  logic [NCHAN-1:0] dly;
  logic [NCHAN-1:0] active;
  logic [NCOMB-1:0] pair;
  logic [GBITS-1:0] timer_q;
  logic             busy_q;
  logic             done_q;
  logic [CBITS-1:0] sacc_q [NCHAN];
  logic [CBITS-1:0] sacc_d [NCHAN];
  logic [CBITS-1:0] pacc_q [NCOMB];
  logic [CBITS-1:0] pacc_d [NCOMB];
  logic [CBITS-1:0] singles_q [NCHAN];
  logic [CBITS-1:0] counts_q [NCOMB];

  assign pulse = channels_i & ~prev_q;

  // Tap 0 is the undelayed pulse; tap k is the pulse k cycles ago.
  generate
    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
      logic [NREGS-2:0] line_q;
      logic [WBITS-1:0] win_q;
      logic [NREGS-1:0] taps;
      logic [IW-1:0]    idx;

      assign taps = {line_q, pulse[gi]};
      assign idx  = (32'(delays_i[gi]) >= NREGS) ? IW'(NREGS - 1) : IW'(delays_i[gi]);
      assign dly[gi]    = taps[idx];
      assign active[gi] = dly[gi] | (win_q != '0);

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          line_q <= '0;
          win_q  <= '0;
        end else begin
          line_q <= taps[NREGS-2:0];
          if (dly[gi]) begin
            win_q <= window_i;
          end else if (win_q != '0) begin
            win_q <= win_q - WBITS'(1);
          end
        end
      end
    end

    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_pi
      for (genvar gj = gi + 1; gj < NCHAN; gj++) begin : g_pj
        localparam int K = gi * NCHAN - gi * (gi + 1) / 2 + (gj - gi - 1);
        assign pair[K] = (dly[gi] & active[gj]) | (dly[gj] & active[gi]);
      end
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < NCHAN; i++) begin
      sacc_d[i] = (sacc_q[i] != C_MAX) ? sacc_q[i] + CBITS'(dly[i]) : sacc_q[i];
    end
    for (int k = 0; k < NCOMB; k++) begin
      pacc_d[k] = (pacc_q[k] != C_MAX) ? pacc_q[k] + CBITS'(pair[k]) : pacc_q[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      prev_q    <= '0;
      timer_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sacc_q    <= '{default: '0};
      pacc_q    <= '{default: '0};
      singles_q <= '{default: '0};
      counts_q  <= '{default: '0};
    end else begin
      prev_q <= channels_i;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i && (gate_period_i != '0)) begin
            sacc_q  <= '{default: '0};
            pacc_q  <= '{default: '0};
            timer_q <= gate_period_i;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          // Abort drops this cycle's events and leaves the snapshot alone.
          if (abort_i) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            sacc_q  <= sacc_d;
            pacc_q  <= pacc_d;
            timer_q <= timer_q - GBITS'(1);
            if (timer_q == GBITS'(1)) begin
              singles_q <= sacc_d;
              counts_q  <= pacc_d;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign singles_o = singles_q;
  assign counts_o  = counts_q;

endmodule

`default_nettype wire
